// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART receive path
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Whole system clocks per line bit; the remainder is dropped, so the
    // sample point drifts by at most one clock per bit.
    function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for one asynchronous input
//   clk, areset_n : clock and asynchronous active-low reset
//   d             : asynchronous input
//   q             : synchronized copy of d, RESET_VAL while in reset
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic areset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with single-entry valid/ready holding register
//   clk, areset_n   : system clock, asynchronous active-low reset
//   rxd_in          : asynchronous serial line, idle high
//   data_read_valid : holding register has an unread byte (data_out)
//   data_read_ready : consumer accepts the byte on valid && ready
//   data_out        : received byte, stable while valid is high
//   frame_error     : one-cycle pulse, stop bit sampled low
//   overrun         : one-cycle pulse, frame completed while holding register full
//   parity_error    : one-cycle pulse, even parity mismatch (UART_RX_PARITY_EN only)
// Optional macro UART_RX_PARITY_EN adds an even-parity bit after data bit 7.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_RATE  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       rxd_in,
    output logic       data_read_valid,
    input  logic       data_read_ready,
    output logic [7:0] data_out,
    output logic       frame_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_rate_check
            $error("uart_rx: CLK_RATE/BAUD_RATE must be at least 4");
        end
    endgenerate

    logic rxd_s;

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk      (clk),
        .areset_n (areset_n),
        .d        (rxd_in),
        .q        (rxd_s)
    );

    rx_state_t      state, state_n;
    logic [CW-1:0]  baud_cnt, baud_n;
    logic [BW-1:0]  bit_cnt, bit_n;
    logic [7:0]     shift_reg, shift_n;
    logic           stop_hi;    // stop bit sampled 1 this cycle
    logic           stop_lo;    // stop bit sampled 0 this cycle
    logic           frame_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_n;
    logic par_bad;
    logic par_err_q;
`endif

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
`ifdef UART_RX_PARITY_EN
            par_bit   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        stop_hi = 1'b0;
        stop_lo = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_bit;
`endif
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                    baud_n  = '0;
                end
            end
            START: begin
                // Checking the start bit at its middle rejects short glitches
                // and aligns every later sample to mid-bit.
                if (baud_cnt == HALF_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_n  = '0;
                    shift_n = {rxd_s, shift_reg[7:1]};
                    if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_n  = '0;
                    par_n   = rxd_s;
                    state_n = STOP;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop-bit so a start bit right behind it is seen.
                if (baud_cnt == BIT_LAST) begin
                    baud_n  = '0;
                    state_n = IDLE;
                    stop_hi = rxd_s;
                    stop_lo = !rxd_s;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign par_bad  = ^{shift_reg, par_bit};
    assign frame_ok = stop_hi && !par_bad;
`else
    assign frame_ok = stop_hi;
`endif

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            data_read_valid <= 1'b0;
            data_out        <= '0;
            frame_error     <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            frame_error <= stop_lo;
            overrun     <= 1'b0;
            if (frame_ok) begin
                // A byte draining this cycle frees the slot for the new one.
                if (!data_read_valid || data_read_ready) begin
                    data_out        <= shift_reg;
                    data_read_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_read_valid && data_read_ready) begin
                data_read_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= (stop_hi || stop_lo) && par_bad;
        end
    end
    assign parity_error = par_err_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 10 clocks per bit
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk;
    logic       areset_n;
    logic       rxd_in;
    logic       data_read_valid;
    logic       data_read_ready;
    logic [7:0] data_out;
    logic       frame_error;
    logic       overrun;
    logic       parity_error;

    uart_rx #(
        .CLK_RATE  (10),
        .BAUD_RATE (1)
    ) dut (
        .clk             (clk),
        .areset_n        (areset_n),
        .rxd_in          (rxd_in),
        .data_read_valid (data_read_valid),
        .data_read_ready (data_read_ready),
        .data_out        (data_out),
        .frame_error     (frame_error),
        .overrun         (overrun),
        .parity_error    (parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int n_vec  = 0;
    int n_err  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte, counts error pulses.
    always @(negedge clk) begin
        if (areset_n) begin
            if (frame_error)  fe_cnt++;
            if (overrun)      ov_cnt++;
            if (parity_error) pe_cnt++;
            if (data_read_valid && data_read_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h expected none", data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        n_err++;
                        $display("FAIL rx_byte: got %0h expected %0h", data_out, e);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) data_read_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_time(input logic b);
        rxd_in = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(^b);
`endif
        bit_time(stop);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
        check(name, exp_q.size(), 0);
    endtask

    int fe0, ov0;

    initial begin
        areset_n        = 1'b0;
        rxd_in          = 1'b1;
        data_read_ready = 1'b0;
        tick(3);
        check("reset_valid", data_read_valid, 0);
        check("reset_data", data_out, 8'h00);
        check("reset_fe", frame_error, 0);
        check("reset_ov", overrun, 0);
        check("reset_pe", parity_error, 0);
        areset_n = 1'b1;
        tick(5);

        // single frame
        data_read_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain("a5_drain");
        tick(CPB);
        check("a5_no_fe", fe_cnt, 0);
        check("a5_no_ov", ov_cnt, 0);
        check("a5_no_pe", pe_cnt, 0);

        // back-to-back frames
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("b2b_drain");
        tick(CPB);

        // overrun with the holding register full
        data_read_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(CPB);
        check("ovr_valid", data_read_valid, 1);
        check("ovr_data", data_out, 8'h3C);
        check("ovr_pulse", ov_cnt - ov0, 1);
        exp_q.push_back(8'h3C);
        data_read_ready = 1'b1;
        tick(1);
        check("ovr_drop_valid", data_read_valid, 0);
        wait_drain("ovr_drain");

        // bad stop bit
        fe0 = fe_cnt;
        send_frame(8'h5A, 1'b0);
        rxd_in = 1'b1;
        tick(3 * CPB);
        check("fe_pulse", fe_cnt - fe0, 1);
        check("fe_no_valid", data_read_valid, 0);

        // short glitch on idle line
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rxd_in = 1'b0;
        tick(3);
        rxd_in = 1'b1;
        tick(3 * CPB);
        check("glitch_valid", data_read_valid, 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_ov", ov_cnt - ov0, 0);

        // reset mid-frame with a byte parked in the holding register
        data_read_ready = 1'b0;
        send_frame(8'h42, 1'b1);
        tick(CPB);
        check("park_valid", data_read_valid, 1);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(i[0]);
        areset_n = 1'b0;
        rxd_in   = 1'b1;
        #1;
        check("mid_reset_valid", data_read_valid, 0);
        check("mid_reset_data", data_out, 8'h00);
        tick(3);
        areset_n = 1'b1;
        tick(2 * CPB);
        data_read_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_drain("post_reset_drain");

        // random stream with random ready
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        rand_ready = 1'b0;
        tick(1);
        data_read_ready = 1'b1;
        wait_drain("rand_drain");
        check("rand_no_ov", ov_cnt - ov0, 0);
        check("rand_no_fe", fe_cnt - fe0, 0);
        check("rand_no_pe", pe_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side partner of the uart_tx serializer: samples an asynchronous 8N1 serial line, reassembles bytes and presents them on a valid/ready read port.
- Sits directly downstream of uart_tx's txd_out, either in loopback or at the device pin. Bench loopback is txd_out -> rxd_in.
- Single-entry holding register. Reports framing and overrun errors as one-cycle pulses.

Parameters:
- CLK_RATE, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s.
- Derived localparams: CLKS_PER_BIT = CLK_RATE/BAUD_RATE (integer division); HALF_BIT = CLKS_PER_BIT/2.
- Elaboration error if CLKS_PER_BIT < 4.

Ports:
- clk  in  1  system clock, rising edge.
- areset_n  in  1  asynchronous active-low reset.
- rxd_in  in  1  serial line, asynchronous, idle high.
- data_read_valid  out  1  holding register contains an unread byte.
- data_read_ready  in  1  consumer accepts the byte when valid && ready on a rising edge.
- data_out  out  8  received byte. Stable while valid is high.
- frame_error  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: a frame completed while the holding register was full and not being drained.
- parity_error  out  1  one-cycle pulse. Tied 0 unless UART_RX_PARITY_EN is defined.

Behaviour:
- Reset (async assert, sync deassert by system):
  - outputs: data_read_valid=0, data_out=0, frame_error=0, overrun=0, parity_error=0.
  - internal: state=IDLE, synchronizer flops=1, counters=0.
- rxd_in passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - rxd_s==0 -> START, baud_cnt=0.
- START:
  - baud_cnt counts up; at baud_cnt==HALF_BIT-1, sample rxd_s.
  - Sample 0 -> DATA, baud_cnt=0, bit_cnt=0.
  - Sample 1 -> false start: IDLE, no outputs.
- DATA:
  - Sample rxd_s each time baud_cnt==CLKS_PER_BIT-1, so sampling stays mid-bit.
  - Shift right into shift_reg, new bit at bit 7. LSB is first on the wire.
  - After bit_cnt reaches 7 and is sampled -> STOP, or -> PARITY when the feature is compiled in.
- STOP:
  - Sample at baud_cnt==CLKS_PER_BIT-1, then return to IDLE immediately (mid-stop-bit) so a back-to-back start bit is caught.
  - Sample 1 -> frame done.
  - Sample 0 -> frame_error pulses the next cycle; byte is discarded.
- Frame done, registered outputs on the next edge:
  - valid==0, or valid && ready this cycle: data_out=shift_reg, data_read_valid=1.
  - valid==1 && !ready: new byte dropped, holding byte retained, overrun pulses.
- valid && ready with no new frame -> data_read_valid=0 next cycle. data_out holds its last value.
- Latency: data_read_valid rises 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks after the rxd_in falling edge, ±1 for synchronizer phase.
- Line held low (break condition):
  - Yields one frame_error, then START re-triggers on the continued low.
  - Each subsequent frame gives frame_error with no valid.
- Counter wrap: baud_cnt is sized $clog2(CLKS_PER_BIT) and never exceeds CLKS_PER_BIT-1.
- Reset mid-frame: partial byte discarded, FSM -> IDLE, holding register cleared.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows data bit 7, sampled in PARITY state at mid-bit.
  - Mismatch -> parity_error pulse alongside frame completion; byte discarded.
  - Stop bit is still checked, and its error is reported independently.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, parity_error tied 0, frame is 8N1.

Decomposition:
- uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - function clks_per_bit(clk_rate, baud_rate).
  - constant DATA_BITS=8.
- One natural sub-module: uart_sync, a 2-flop synchronizer with parameterised reset value (1 here), reusable by other async inputs.

Test Plan (CLK_RATE=10, BAUD_RATE=1, so CLKS_PER_BIT=10):
- Drive 0xA5 as 8N1 bit-times with ready=1 -> one valid pulse, data_out=0xA5, no error pulses.
- Two back-to-back frames 0x00 then 0xFF (stop bit immediately followed by start bit), ready=1 -> two valids, data 0x00 then 0xFF.
- ready=0, send 0x3C then 0xC3 -> valid stays 1 with data_out=0x3C, overrun pulses once. Raise ready -> valid drops next cycle.
- Frame 0x5A with stop bit driven 0 -> frame_error one cycle, data_read_valid stays 0.
- Low glitch of 3 clocks on idle line -> no state beyond START, no outputs. Assert areset_n=0 at bit 4 of a frame -> outputs reset, the next clean frame 0x81 is received correctly.
- Loopback uart_tx -> uart_rx with 200 random bytes, ready randomly toggled at ≥50% -> received sequence equals sent sequence, with no overrun as long as ready is high at least once per byte time.
